// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time UART program loader.
package loader_pkg;

  localparam int FRAME_HDR_BYTES = 2;
  localparam int BYTES_PER_WORD  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/loader_uart_rx.sv
// 8N1 UART byte receiver: 2-flop synchroniser, half-bit start qualification, centre sampling.
// rx_valid / rx_err are mutually exclusive single-cycle pulses at the stop-bit centre.
module loader_uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err
);
  localparam int             CW   = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]  FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    r_sync;
  rx_state_t     r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          w_rx, w_tc;

  assign w_rx = r_sync[1];
  assign w_tc = (r_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync  <= 2'b11;
      r_state <= RX_IDLE;
    end else begin
      r_sync  <= {r_sync[0], rx};
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RX_IDLE:  if (!w_rx) w_next = RX_START;
      RX_START: if (w_tc) w_next = w_rx ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_tc && (r_bit == 3'd7)) w_next = RX_STOP;
      RX_STOP:  if (w_tc) w_next = RX_IDLE;
      default:  w_next = RX_IDLE;
    endcase
  end

  // Idle keeps the timer armed with a half bit so the start bit is re-checked at its centre.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      if (r_state == RX_IDLE) begin
        r_cnt <= HALF;
        r_bit <= '0;
      end else if (!w_tc) begin
        r_cnt <= r_cnt - 1'b1;
      end else begin
        r_cnt <= FULL;
        if (r_state == RX_DATA) begin
          r_shift <= {w_rx, r_shift[7:1]};
          r_bit   <= r_bit + 3'd1;
        end
        if (r_state == RX_STOP) begin
          if (w_rx) begin
            rx_valid <= 1'b1;
            rx_data  <= r_shift;
          end else begin
            rx_err <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot-time UART loader: one length-prefixed frame of big-endian words into memory after reset.
// Define LOADER_CHECKSUM_EN to require an XOR trailer byte after the last word.
module program_loader
  import loader_pkg::*;
#(
  parameter int          CLK_HZ    = 100_000_000,
  parameter int          BAUD      = 115200,
  parameter logic [15:0] BASE_ADDR = 16'd0,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx,
  output logic        mem_en,
  output logic        mem_wen,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] words_loaded
);
  localparam int         CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam logic [1:0] LAST_BYTE    = 2'(BYTES_PER_WORD - 1);

  logic [7:0]  w_rx_data;
  logic        w_rx_valid, w_rx_err;
  logic [15:0] w_len_in;
  logic        w_last_word;
  state_t      r_state, w_next;
  logic [7:0]  r_len_hi;
  logic [15:0] r_len, r_idx, r_addr;
  logic [23:0] r_word;
  logic [31:0] r_din;
  logic [1:0]  r_byte_cnt;

  loader_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .reset    (reset),
    .rx       (uart_rx),
    .rx_data  (w_rx_data),
    .rx_valid (w_rx_valid),
    .rx_err   (w_rx_err)
  );

  assign w_len_in    = {r_len_hi, w_rx_data};
  assign w_last_word = ((r_idx + 16'd1) == r_len);

  assign mem_en       = (r_state == S_WRITE);
  assign mem_wen      = (r_state == S_WRITE);
  assign mem_addr     = r_addr;
  assign mem_din      = r_din;
  assign load_done    = (r_state == S_DONE);
  assign load_error   = (r_state == S_ERR);
  assign words_loaded = r_idx;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_xor;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_xor <= '0;
    else if (w_rx_valid && (r_state == S_IDLE || r_state == S_LEN_LO || r_state == S_DATA))
      r_xor <= r_xor ^ w_rx_data;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // State | meaning:  IDLE wait LEN_HI | LEN_LO wait LEN_LO | DATA collect word bytes
  //   WRITE one-cycle strobe | CHK wait trailer | DONE loaded (terminal) | ERR failed (terminal)
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_rx_err)        w_next = S_ERR;
        else if (w_rx_valid) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (w_rx_err) w_next = S_ERR;
        else if (w_rx_valid) begin
          if (w_len_in == 16'd0)               w_next = S_DONE;
          else if (int'(w_len_in) > MAX_WORDS) w_next = S_ERR;
          else                                 w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_rx_err)                                      w_next = S_ERR;
        else if (w_rx_valid && (r_byte_cnt == LAST_BYTE)) w_next = S_WRITE;
      end
      S_WRITE: begin
        if (w_rx_err)         w_next = S_ERR;
        else if (w_last_word)
`ifdef LOADER_CHECKSUM_EN
          w_next = S_CHK;
`else
          w_next = S_DONE;
`endif
        else                  w_next = S_DATA;
      end
      S_CHK: begin
`ifdef LOADER_CHECKSUM_EN
        if (w_rx_err)        w_next = S_ERR;
        else if (w_rx_valid) w_next = (w_rx_data == r_xor) ? S_DONE : S_ERR;
`else
        w_next = S_ERR;
`endif
      end
      S_DONE:  w_next = S_DONE;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_ERR;
    endcase
  end

  // mem_addr/mem_din are loaded only on the 4th byte so they hold between strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len_hi   <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_addr     <= '0;
      r_word     <= '0;
      r_din      <= '0;
      r_byte_cnt <= '0;
    end else begin
      if (w_rx_valid) begin
        unique case (r_state)
          S_IDLE:   r_len_hi <= w_rx_data;
          S_LEN_LO: r_len    <= w_len_in;
          S_DATA: begin
            r_word     <= {r_word[15:0], w_rx_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == LAST_BYTE) begin
              r_din  <= {r_word, w_rx_data};
              r_addr <= BASE_ADDR + r_idx;
            end
          end
          default: ;
        endcase
      end
      if (r_state == S_WRITE) r_idx <= r_idx + 16'd1;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: vector table, hand sequences and random frames
// checked against a frame-parsing reference model (honours LOADER_CHECKSUM_EN).
module tb_program_loader;

  localparam int          CLK_HZ = 1_000_000;
  localparam int          BAUD   = 100_000;
  localparam int          CPB    = CLK_HZ / BAUD;
  localparam int          MAXW   = 4;
  localparam logic [15:0] BASE   = 16'hFFFE;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        uart_rx = 1'b1;
  logic        mem_en, mem_wen, load_done, load_error;
  logic [15:0] mem_addr, words_loaded;
  logic [31:0] mem_din;

  program_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk          (clk),
    .reset        (reset),
    .uart_rx      (uart_rx),
    .mem_en       (mem_en),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          glitch = 0;
  logic        prev_wen = 1'b0;
  logic [47:0] obs_q[$];
  logic [47:0] exp_q[$];

  // Write monitor: records every strobe, flags en/wen disagreement or strobes longer than a cycle.
  always @(negedge clk) begin
    if (reset) begin
      obs_q.delete();
      prev_wen = 1'b0;
    end else begin
      if (mem_wen) obs_q.push_back({mem_addr, mem_din});
      if ((mem_en !== mem_wen) || (mem_wen && prev_wen)) glitch++;
      prev_wen = mem_wen;
    end
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop, input bit win);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = !bad_stop;
    if (win) check("done_before_stop", 96'(load_done), 96'd0);
    repeat (CPB) @(negedge clk);
    if (win) check("done_by_stop_end", 96'(load_done), 96'd1);
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset;
    uart_rx = 1'b1;
    reset   = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [7:0] xsum(input logic [7:0] q[$]);
    logic [7:0] x = 8'h00;
    foreach (q[i]) x ^= q[i];
    return x;
  endfunction

  // Reference: parse the frame from its byte list; bad_at is the index of a byte with a bad stop bit.
  task automatic model(input logic [7:0] bq[$], input int bad_at,
                       output bit e_done, output bit e_err, output int e_words);
    int avail, n, full;
    exp_q.delete();
    e_done = 0; e_err = 0; e_words = 0;
    avail = (bad_at >= 0) ? bad_at : bq.size();
    if (avail < 2) begin e_err = (bad_at >= 0); return; end
    n = {16'd0, bq[0], bq[1]};
    if (n == 0) begin e_done = 1; return; end
    if (n > MAXW) begin e_err = 1; return; end
    full = (avail - 2) / 4;
    if (full > n) full = n;
    for (int w = 0; w < full; w++)
      exp_q.push_back({16'(BASE + w), bq[2+4*w], bq[3+4*w], bq[4+4*w], bq[5+4*w]});
    e_words = full;
    if (full < n) begin e_err = (bad_at >= 0); return; end
`ifdef LOADER_CHECKSUM_EN
    begin
      int t;
      logic [7:0] x;
      t = 2 + 4 * n;
      if (avail <= t) begin e_err = (bad_at >= 0); return; end
      x = 8'h00;
      for (int i = 0; i < t; i++) x ^= bq[i];
      e_done = (bq[t] == x);
      e_err  = !e_done;
    end
`else
    e_done = 1;
`endif
  endtask

  task automatic run_frame(input logic [7:0] q[$], input int bad_at, input string tag);
    bit ed, ee;
    int ew, g0, last;
    g0   = glitch;
    last = (bad_at >= 0) ? bad_at : q.size() - 1;
    for (int i = 0; i <= last; i++) send_byte(q[i], (i == bad_at), 1'b0);
    repeat (3 * CPB) @(negedge clk);
    model(q, bad_at, ed, ee, ew);
    check({tag, "_done"}, 96'(load_done), 96'(ed));
    check({tag, "_err"}, 96'(load_error), 96'(ee));
    check({tag, "_words"}, 96'(words_loaded), 96'(ew));
    check({tag, "_nwrites"}, 96'(obs_q.size()), 96'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check({tag, "_write"}, 96'(obs_q[i]), 96'(exp_q[i]));
    check({tag, "_strobe"}, 96'(glitch - g0), 96'd0);
  endtask

  typedef struct {
    int           len;
    logic [159:0] v;
    int           bad_at;
    bit           trl;
    int           post;
    bit           e_done;
    bit           e_err;
    int           e_words;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mkv(int len, logic [159:0] v, int bad_at, bit trl, int post,
                               bit d, bit e, int w);
    vec_t r;
    r.len = len; r.v = v; r.bad_at = bad_at; r.trl = trl; r.post = post;
    r.e_done = d; r.e_err = e; r.e_words = w;
    return r;
  endfunction

  initial begin
    logic [7:0]   q[$];
    logic [159:0] tv;
    int           n, bad_at;

    vt.push_back(mkv(10, 160'h0002DEADBEEF12345678, -1, 1, -1, 1, 0, 2));
    vt.push_back(mkv(2, 160'h0000, -1, 0, -1, 1, 0, 0));
    vt.push_back(mkv(2, 160'h0401, -1, 0, -1, 0, 1, 0));
    vt.push_back(mkv(3, 160'h0001AA, 2, 0, -1, 0, 1, 0));
    vt.push_back(mkv(18, 160'h00040102030405060708090A0B0C0D0E0F10, -1, 1, -1, 1, 0, 4));
    vt.push_back(mkv(2, 160'h0005, -1, 0, -1, 0, 1, 0));
    vt.push_back(mkv(14, 160'h0003A1A2A3A4B1B2B3B4C1C2C3C4, -1, 1, -1, 1, 0, 3));
    vt.push_back(mkv(10, 160'h00021122334455667788, -1, 1, 8'h99, 1, 0, 2));
    vt.push_back(mkv(7, 160'h00020102030405, 6, 0, -1, 0, 1, 1));
`ifdef LOADER_CHECKSUM_EN
    vt.push_back(mkv(7, 160'h00010102030405, -1, 0, -1, 1, 0, 1));
    vt.push_back(mkv(7, 160'h00010102030404, -1, 0, -1, 0, 1, 1));
`endif

    @(negedge clk);
    check("reset_outputs",
          96'({mem_en, mem_wen, mem_addr, mem_din, load_done, load_error, words_loaded}), 96'd0);

    for (int k = 0; k < vt.size(); k++) begin
      do_reset();
      q.delete();
      tv = vt[k].v;
      for (int i = 0; i < vt[k].len; i++) q.push_back(tv[8*(vt[k].len-1-i) +: 8]);
`ifdef LOADER_CHECKSUM_EN
      if (vt[k].trl) q.push_back(xsum(q));
`endif
      if (vt[k].post >= 0) q.push_back(8'(vt[k].post));
      run_frame(q, vt[k].bad_at, $sformatf("vec%0d", k));
      check($sformatf("vec%0d_tbl_done", k), 96'(load_done), 96'(vt[k].e_done));
      check($sformatf("vec%0d_tbl_err", k), 96'(load_error), 96'(vt[k].e_err));
      check($sformatf("vec%0d_tbl_words", k), 96'(words_loaded), 96'(vt[k].e_words));
    end

    // Empty frame: done appears right after the second byte, and nothing is ever written.
    do_reset();
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b1);
    repeat (3 * CPB) @(negedge clk);
    check("empty_nwrites", 96'(obs_q.size()), 96'd0);
    check("empty_err", 96'(load_error), 96'd0);

    // Reset mid-frame: outputs clear immediately, then a fresh one-word frame loads cleanly.
    do_reset();
    q = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    foreach (q[i]) send_byte(q[i], 1'b0, 1'b0);
    check("pre_reset_words", 96'(words_loaded), 96'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_outputs",
          96'({mem_en, mem_wen, mem_addr, mem_din, load_done, load_error, words_loaded}), 96'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    q = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
`ifdef LOADER_CHECKSUM_EN
    q.push_back(xsum(q));
`endif
    run_frame(q, -1, "after_reset");
    check("after_reset_single", 96'(obs_q.size()), 96'd1);
    if (obs_q.size() > 0) check("after_reset_word", 96'(obs_q[0]), 96'({BASE, 32'hCAFEBABE}));

    for (int r = 0; r < 10; r++) begin
      do_reset();
      n = ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(0, MAXW);
      q.delete();
      q.push_back(8'(n >> 8));
      q.push_back(8'(n));
      if (n <= MAXW) begin
        for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom_range(0, 255)));
`ifdef LOADER_CHECKSUM_EN
        if (n > 0) begin
          q.push_back(xsum(q));
          if ($urandom_range(0, 2) == 0) q[q.size()-1] ^= 8'($urandom_range(1, 255));
        end
`endif
      end
      bad_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, q.size() - 1) : -1;
      run_frame(q, bad_at, $sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
